cpu_bus_responder: RTL and testbench



---
 rtl/cpu6502_bus_pkg.sv | 30 +++
 rtl/cpu_bus_log_fifo.sv | 67 ++++++
 rtl/cpu_bus_responder.sv | 175 +++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_bus_pkg.sv
// Shared definitions for the cpu6502 bus responder and its write-log FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional feature macro: BUS_TRACE_READS_EN. When it is defined, log entries
// carry an is_read kind bit.
package cpu6502_bus_pkg;

   // Register offsets inside the 16-byte MMIO window
   localparam logic [3:0] MMIO_STATUS = 4'd0;
   localparam logic [3:0] MMIO_COUNT  = 4'd1;
   localparam logic [3:0] MMIO_DROPS  = 4'd2;

   // Reset vector bytes
   localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
   localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

   // Bit positions in the STATUS register
   localparam int STAT_VALID_BIT = 0;
   localparam int STAT_OVF_BIT   = 1;

   typedef struct packed {
`ifdef BUS_TRACE_READS_EN
      logic        is_read;
`endif
      logic [15:0] addr;
      logic [7:0]  data;
   } log_entry_t;

endpackage

// File: rtl/cpu_bus_log_fifo.sv
// First-word-fall-through FIFO of bus log entries.
// Latency: a pushed entry is visible at head on the next clk.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk/reset (sync, active-high); push/push_dat write side;
// pop/head read side; empty, full and count report occupancy (0..DEPTH).
module cpu_bus_log_fifo
   import cpu6502_bus_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  log_entry_t               push_dat,
   input  logic                     pop,
   output log_entry_t               head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   log_entry_t    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_pop_ok;
   logic          w_push_ok;

   assign empty = (r_count == '0);
   assign full  = (r_count == FULL_CNT);
   assign count = r_count;
   assign head  = r_mem[r_rptr];

   // A pop frees the slot in the same cycle, so a full FIFO still accepts
   // a push that coincides with a pop.
   assign w_pop_ok  = pop & ~empty;
   assign w_push_ok = push & (~full | w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_bus_responder.sv
// Bus responder for cpu6502: work RAM, reset vector, MMIO status and a store log.
// Latency: idata is registered, 1 clk after addr; log entries appear 1 clk after the store.
// Backpressure: log drained via log_valid/log_ready; stores into a full log are dropped and counted.
//
// Ports: clk/reset (sync, active-high); addr/odata/rw/clk2 from the CPU;
// idata back to the CPU; log_valid/log_addr/log_data/log_ready drain port;
// log_overflow sticky drop flag.
// Optional feature macro: BUS_TRACE_READS_EN adds read tracing and log_is_read.
module cpu_bus_responder
   import cpu6502_bus_pkg::*;
#(
   parameter int          RAM_AW    = 11,
   parameter logic [15:0] RESET_VEC = 16'h0000,
   parameter logic [15:0] MMIO_BASE = 16'hD000,
   parameter int          LOG_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  odata,
   input  logic        rw,
   input  logic        clk2,
   output logic [7:0]  idata,
   output logic        log_valid,
   output logic [15:0] log_addr,
   output logic [7:0]  log_data,
   input  logic        log_ready,
`ifdef BUS_TRACE_READS_EN
   output logic        log_is_read,
`endif
   output logic        log_overflow
);

   localparam int CW       = $clog2(LOG_DEPTH) + 1;
   localparam int RAM_SIZE = 1 << RAM_AW;

   logic [7:0]  r_ram [RAM_SIZE];
   logic        r_clk2_q;
   logic [7:0]  r_idata;
   logic        r_overflow;
   logic [7:0]  r_drops;

   logic        w_in_ram;
   logic        w_in_mmio;
   logic        w_store;
   logic        w_push;
   logic        w_pop;
   logic        w_drop;
   logic        w_clr;
   logic        w_empty;
   logic        w_full;
   logic [CW-1:0] w_count;
   logic [7:0]  w_rd_dat;
   logic [7:0]  w_status;
   log_entry_t  w_push_dat;
   log_entry_t  w_head;

   assign w_in_ram  = ((32'(addr) >> RAM_AW) == 32'd0);
   assign w_in_mmio = (addr[15:4] == MMIO_BASE[15:4]);

   // Stores are recognised on the clk cycle in which phi2 is seen rising.
   assign w_store = clk2 & ~r_clk2_q & ~rw & ~reset;

`ifdef BUS_TRACE_READS_EN
   logic w_rd_trace;
   // Reads are logged on the phi2 fall, carrying the data the CPU latched.
   assign w_rd_trace = ~clk2 & r_clk2_q & rw & ~reset;
   assign w_push     = w_store | w_rd_trace;
   always_comb begin
      w_push_dat         = '0;
      w_push_dat.is_read = w_rd_trace;
      w_push_dat.addr    = addr;
      w_push_dat.data    = w_rd_trace ? r_idata : odata;
   end
   assign log_is_read = w_empty ? 1'b0 : w_head.is_read;
`else
   assign w_push = w_store;
   always_comb begin
      w_push_dat      = '0;
      w_push_dat.addr = addr;
      w_push_dat.data = odata;
   end
`endif

   assign w_pop  = ~w_empty & log_ready;
   assign w_drop = w_push & w_full & ~w_pop;
   assign w_clr  = w_store & ~w_in_ram & w_in_mmio & (addr[3:0] == MMIO_STATUS);

   cpu_bus_log_fifo #(
      .DEPTH (LOG_DEPTH)
   ) u_log_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (w_push),
      .push_dat (w_push_dat),
      .pop      (w_pop),
      .head     (w_head),
      .empty    (w_empty),
      .full     (w_full),
      .count    (w_count)
   );

   always_comb begin
      w_status                 = 8'h00;
      w_status[STAT_VALID_BIT] = ~w_empty;
      w_status[STAT_OVF_BIT]   = r_overflow;
   end

   // Read decode, first match wins.
   always_comb begin
      w_rd_dat = 8'hFF;
      if (w_in_ram) begin
         w_rd_dat = r_ram[addr[RAM_AW-1:0]];
      end else if (addr == VEC_LO_ADDR) begin
         w_rd_dat = RESET_VEC[7:0];
      end else if (addr == VEC_HI_ADDR) begin
         w_rd_dat = RESET_VEC[15:8];
      end else if (w_in_mmio) begin
         case (addr[3:0])
            MMIO_STATUS: w_rd_dat = w_status;
            MMIO_COUNT:  w_rd_dat = 8'(w_count);
            MMIO_DROPS:  w_rd_dat = r_drops;
            default:     w_rd_dat = 8'hFF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_store && w_in_ram) begin
         r_ram[addr[RAM_AW-1:0]] <= odata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk2_q   <= 1'b0;
         r_idata    <= 8'hFF;
         r_overflow <= 1'b0;
         r_drops    <= 8'h00;
      end else begin
         r_clk2_q <= clk2;
         r_idata  <= w_rd_dat;
         // A drop in the same cycle as a clear leaves exactly one drop recorded.
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (w_clr)                 r_drops <= 8'h01;
            else if (r_drops != 8'hFF) r_drops <= r_drops + 8'h01;
         end else if (w_clr) begin
            r_overflow <= 1'b0;
            r_drops    <= 8'h00;
         end
      end
   end

   assign idata        = r_idata;
   assign log_valid    = ~w_empty;
   assign log_addr     = w_empty ? 16'h0000 : w_head.addr;
   assign log_data     = w_empty ? 8'h00 : w_head.data;
   assign log_overflow = r_overflow;

   // Simulation-only sanity checks on the configuration and bus protocol.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (RAM_SIZE <= int'(MMIO_BASE))
            else $error("RAM range overlaps MMIO window");
         assert (RAM_SIZE <= int'(VEC_LO_ADDR))
            else $error("RAM range overlaps reset vector");
`ifdef BUS_TRACE_READS_EN
         assert (!(w_store && w_rd_trace))
            else $error("read trace and store in the same cycle");
`endif
      end
   end

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  odata = 8'h00;
   logic        rw = 1'b1;
   logic        clk2 = 1'b0;
   logic        log_ready = 1'b0;
   logic [7:0]  idata;
   logic        log_valid;
   logic [15:0] log_addr;
   logic [7:0]  log_data;
   logic        log_overflow;

   cpu_bus_responder #(
      .RAM_AW    (11),
      .RESET_VEC (16'h1234),
      .MMIO_BASE (16'hD000),
      .LOG_DEPTH (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .odata        (odata),
      .rw           (rw),
      .clk2         (clk2),
      .idata        (idata),
      .log_valid    (log_valid),
      .log_addr     (log_addr),
      .log_data     (log_data),
      .log_ready    (log_ready),
      .log_overflow (log_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: memory map and log behaviour at transaction level.
   logic [7:0]  m_ram [2048];
   bit          m_known [2048];
   logic [23:0] m_q [$];
   bit          m_ovf = 0;
   int          m_drops = 0;
   bit          m_clk2_q = 0;
   bit          rand_ready = 0;

   task automatic mread(input logic [15:0] a, output bit kn, output logic [7:0] d);
      kn = 1;
      d  = 8'hFF;
      if (int'(a) < 2048) begin
         kn = m_known[int'(a)];
         d  = m_ram[int'(a)];
      end else if (a == 16'hFFFC) d = 8'h34;
      else if (a == 16'hFFFD) d = 8'h12;
      else if (a[15:4] == 12'hD00) begin
         case (a[3:0])
            4'd0:    d = {6'b0, m_ovf, m_q.size() != 0};
            4'd1:    d = 8'(m_q.size());
            4'd2:    d = 8'(m_drops);
            default: d = 8'hFF;
         endcase
      end
   endtask

   // One clock: predict the effect of the current inputs, advance, compare.
   task automatic tick();
      bit st, pop, was_full, clr, kn;
      logic [7:0] ex;
      if (rand_ready) log_ready = ($urandom_range(0, 2) == 0);
      mread(addr, kn, ex);
      if (reset) begin
         kn = 1;
         ex = 8'hFF;
         m_q.delete();
         m_ovf   = 0;
         m_drops = 0;
         m_clk2_q = 0;
      end else begin
         st       = clk2 && !m_clk2_q && !rw;
         pop      = (m_q.size() != 0) && log_ready;
         was_full = (m_q.size() == 8);
         clr      = st && (addr == 16'hD000);
         if (pop) void'(m_q.pop_front());
         if (st) begin
            if (was_full && !pop) begin
               m_ovf = 1;
               if (clr) m_drops = 1;
               else if (m_drops < 255) m_drops++;
            end else begin
               m_q.push_back({addr, odata});
               if (clr) begin
                  m_ovf   = 0;
                  m_drops = 0;
               end
            end
            if (int'(addr) < 2048) begin
               m_ram[int'(addr)]   = odata;
               m_known[int'(addr)] = 1;
            end
         end
         m_clk2_q = clk2;
      end
      @(posedge clk);
      #1;
      if (kn) check("idata", 32'(idata), 32'(ex));
      check("log_valid", 32'(log_valid), 32'(m_q.size() != 0));
      check("log_head", 32'({log_addr, log_data}), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
      check("log_overflow", 32'(log_overflow), 32'(m_ovf));
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; odata = d; rw = 1'b0; clk2 = 1'b0;
      tick();
      clk2 = 1'b1;
      tick();
      tick();
      clk2 = 1'b0;
      tick();
      rw = 1'b1;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [7:0] v);
      addr = a; rw = 1'b1; clk2 = 1'b0;
      tick();
      v = idata;
      clk2 = 1'b1;
      tick();
      clk2 = 1'b0;
      tick();
   endtask

   logic [7:0] v;
   logic [15:0] ra;

   initial begin
      // Reset state
      reset = 1'b1;
      tick();
      tick();
      check("rst_idata", 32'(idata), 32'hFF);
      check("rst_log_addr", 32'(log_addr), 32'h0);
      check("rst_log_data", 32'(log_data), 32'h0);
      reset = 1'b0;
      tick();

      // Vector bytes and unmapped read, one clk after each address change
      rw = 1'b1;
      addr = 16'hFFFC; tick(); check("vec_lo", 32'(idata), 32'h34);
      addr = 16'hFFFD; tick(); check("vec_hi", 32'(idata), 32'h12);
      addr = 16'h8000; tick(); check("unmapped", 32'(idata), 32'hFF);

      // Bus traffic of LDA #$01; CMP #$01; STA $99 : one store
      bus_rd(16'hFFFC, v);
      bus_rd(16'hFFFD, v);
      bus_wr(16'h0099, 8'h01);
      bus_rd(16'hD001, v); check("prog_count", 32'(v), 32'h1);
      check("prog_head", 32'({log_addr, log_data}), 32'h009901);
      log_ready = 1'b1; tick(); log_ready = 1'b0;
      check("prog_empty", 32'(log_valid), 32'h0);
      bus_rd(16'h0099, v); check("lda_99", 32'(v), 32'h01);

      // Nine stores into an 8-deep log with no consumer
      for (int i = 0; i < 9; i++) bus_wr(16'h0010 + 16'(i), 8'hA0 + 8'(i));
      bus_rd(16'hD001, v); check("ovf_count", 32'(v), 32'h8);
      bus_rd(16'hD000, v); check("ovf_status", 32'(v), 32'h3);
      bus_rd(16'hD002, v); check("ovf_drops", 32'(v), 32'h1);
      check("ovf_head", 32'({log_addr, log_data}), 32'h0010A0);

      // Store event coinciding with a pop while full
      addr = 16'h0020; odata = 8'h55; rw = 1'b0; clk2 = 1'b0;
      tick();
      clk2 = 1'b1; log_ready = 1'b1;
      tick();
      log_ready = 1'b0;
      tick();
      clk2 = 1'b0;
      tick();
      rw = 1'b1;
      bus_rd(16'hD001, v); check("pp_count", 32'(v), 32'h8);
      bus_rd(16'hD000, v); check("pp_status", 32'(v), 32'h3);
      bus_rd(16'hD002, v); check("pp_drops", 32'(v), 32'h1);
      log_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k < 7) check("pp_drain", 32'({log_addr, log_data}),
                          32'({16'h0011 + 16'(k), 8'hA1 + 8'(k)}));
         else       check("pp_last", 32'({log_addr, log_data}), 32'h002055);
         tick();
      end
      log_ready = 1'b0;
      check("pp_empty", 32'(log_valid), 32'h0);

      // Clear while overflowed with an empty log
      bus_wr(16'hD000, 8'h00);
      check("clr_entry", 32'({log_addr, log_data}), 32'hD00000);
      log_ready = 1'b1; tick(); log_ready = 1'b0;
      bus_rd(16'hD000, v); check("clr_status", 32'(v), 32'h00);
      bus_rd(16'hD002, v); check("clr_drops", 32'(v), 32'h00);

      // Reset with three entries queued
      for (int i = 0; i < 3; i++) bus_wr(16'h0040 + 16'(i), 8'(i));
      bus_rd(16'hD001, v); check("mid_count", 32'(v), 32'h3);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", 32'(log_valid), 32'h0);
      reset = 1'b0;
      bus_rd(16'hD001, v); check("mid_rst_count", 32'(v), 32'h0);
      bus_rd(16'h0099, v); check("mid_rst_ram", 32'(v), 32'h01);

      // Randomised traffic with a random consumer
      rand_ready = 1;
      repeat (400) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: ra = 16'($urandom_range(0, 63));
            5:             ra = 16'hD000 + 16'($urandom_range(0, 15));
            6:             ra = 16'hFFFC + 16'($urandom_range(0, 3));
            7:             ra = 16'($urandom);
            default:       ra = 16'($urandom_range(0, 2047));
         endcase
         if ($urandom_range(0, 1) == 1) bus_wr(ra, 8'($urandom));
         else bus_rd(ra, v);
      end
      rand_ready = 0;
      log_ready = 1'b1;
      repeat (10) tick();
      check("final_empty", 32'(log_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
